// File: rtl/nam85_pkg.sv
// Shared constants and types for the display output path.
// Default geometry here matches the original single 8-bit display latch widened to four channels.
package nam85_pkg;

  localparam int BUS_W       = 16;
  localparam int DATA_W_DEF  = 8;
  localparam int N_CH_DEF    = 4;
  localparam int DEPTH_DEF   = 8;
  localparam int CH_W_DEF    = (N_CH_DEF > 1) ? $clog2(N_CH_DEF) : 1;

  // Bit of the controller word that carries the display strobe.
  localparam int DISPLAY_BIT = 9;

  typedef struct packed {
    logic [CH_W_DEF-1:0]   ch;
    logic [DATA_W_DEF-1:0] data;
  } display_entry_t;

endpackage

// File: rtl/display_port_sync_fifo.sv
// Generic synchronous FIFO; head is mem[rd_ptr], no bypass.
// Latency: a push is visible at the head one cycle later.
// Backpressure: caller must not push when full (unless popping) nor pop when empty.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_out,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_dat,
  output logic [WIDTH-1:0] rd_dat,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage is reset too so the head reads 0 out of reset and after a mid-run reset.
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_dat = mem[rd_ptr];
  assign full   = (count == (PTR_W+1)'(DEPTH));
  assign empty  = (count == '0);

endmodule

// File: rtl/display_port.sv
// Captures bus values on the display strobe into a {channel,data} FIFO plus per-channel shadows.
// Latency: one cycle from strobe to out_valid; shadows update on the same edge as the push.
// Backpressure: full captures are dropped (sticky overflow); with DISPLAY_PORT_BACKPRESSURE_EN, hlt_req stalls the CPU instead.
module display_port
  import nam85_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_CH   = N_CH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk_out,
  input  logic              rst,
  input  logic              display,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic [PTR_W:0]    count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  input  logic              overflow_clr,
  input  logic [CH_W-1:0]   shadow_sel,
  output logic [DATA_W-1:0] shadow_out,
  output logic              hlt_req
);

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            wr_entry;
  entry_t            head;
  logic              pop;
  logic              push_ok;
  logic              drop;
  logic [DATA_W-1:0] shadow [N_CH];

  assign pop      = out_valid & out_ready;
  assign push_ok  = display & (~full | pop);
  assign drop     = display & full & ~pop;
  assign wr_entry = '{ch: ch_sel, data: data_in};

  sync_fifo #(
    .WIDTH (CH_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_out (clk_out),
    .rst     (rst),
    .push    (push_ok),
    .pop     (pop),
    .wr_dat  (wr_entry),
    .rd_dat  (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign out_valid = ~empty;
  assign out_data  = head.data;
  assign out_ch    = head.ch;

  // A drop in the same cycle as a clear wins, so no lost capture goes unreported.
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

  // Out-of-range channel numbers still go through the FIFO but match no shadow.
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) shadow[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (push_ok && (ch_sel == CH_W'(i))) shadow[i] <= data_in;
      end
    end
  end

  always_comb begin
    shadow_out = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (shadow_sel == CH_W'(i)) shadow_out = shadow[i];
    end
  end

`ifdef DISPLAY_PORT_BACKPRESSURE_EN
  assign hlt_req = full & ~pop;
`else
  assign hlt_req = 1'b0;
`endif

endmodule
